hls_deadlock_monitor_param: RTL

Parametrised deadlock monitor for HLS-generated streaming kernels (StreamingMaxPool and siblings). It combines the block flags of child monitors with the AXI-Stream stall flags of the enclosing instance. It reports a deadlock only when the condition holds for a programmable number of consecutive cycles. It can hold the report until software clears it, and it captures which stream and which child caused it. It is instantiated once per hierarchy level in place of the fixed single-child, two-stream monitors, and its `block` output feeds the parent level.

---
 rtl/hls_deadlock_monitor_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hls_deadlock_monitor_param.sv
// hls_deadlock_monitor_param
// Deadlock monitor for one hierarchy level of an HLS streaming kernel.
// A deadlock candidate needs an enabled child reporting block, at least one
// stalled AXI-Stream and a design that is not fully idle. The report asserts
// only after PERSIST_CYCLES consecutive candidate cycles, and it can be held
// until software clears it. On entry to BLOCKED the monitor captures the
// offending stream index and the child mask, and keeps them until the next
// entry or reset.
module hls_deadlock_monitor_param #(
   parameter int NUM_AXIS       = 2,
   parameter int NUM_INST       = 4,
   parameter int NUM_SUB        = 1,
   parameter int PERSIST_CYCLES = 1,
   parameter bit STICKY         = 1'b0,
   parameter int AXIS_ID_W      = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_AXIS-1:0]  axis_block_sigs,
   input  logic [NUM_INST-1:0]  inst_idle_sigs,
   input  logic [NUM_SUB-1:0]   inst_block_sigs,
   input  logic [NUM_SUB-1:0]   sub_block,
   input  logic                 clear,
   output logic                 block,
   output logic                 block_event,
   output logic [AXIS_ID_W-1:0] block_axis_id,
   output logic [NUM_SUB-1:0]   block_sub_mask
);

   localparam int                CNT_W   = $clog2(PERSIST_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PERSIST_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_ARMING, S_BLOCKED} state_t;

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic                 w_cand;
   logic                 w_enter;
   logic [NUM_SUB-1:0]   w_sub_hit;
   logic [AXIS_ID_W-1:0] w_low_id;
   logic                 r_event;
   logic [AXIS_ID_W-1:0] r_axis_id;
   logic [NUM_SUB-1:0]   r_sub_mask;

   assign w_sub_hit = sub_block & inst_block_sigs;
   // A fully idle design is never a deadlock, whatever the stall flags say.
   assign w_cand    = (|w_sub_hit) & (|axis_block_sigs) & ~(&inst_idle_sigs);

   // Priority encoder: index of the lowest stalled stream.
   always_comb begin
      w_low_id = '0;
      for (int i = NUM_AXIS - 1; i >= 0; i--) begin
         if (axis_block_sigs[i]) w_low_id = AXIS_ID_W'(i);
      end
   end

   // Next-state and persistence counter; clear beats a simultaneous candidate.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cand) begin
                  if (PERSIST_CYCLES == 1) begin
                     w_state_nxt = S_BLOCKED;
                     w_cnt_nxt   = CNT_MAX;
                  end else begin
                     w_state_nxt = S_ARMING;
                     w_cnt_nxt   = CNT_W'(1);
                  end
               end else begin
                  w_cnt_nxt = '0;
               end
            end
            S_ARMING: begin
               if (!w_cand) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else if ((r_cnt + CNT_W'(1)) == CNT_MAX) begin
                  w_state_nxt = S_BLOCKED;
                  w_cnt_nxt   = CNT_MAX;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_BLOCKED: begin
               // A sticky report only leaves through clear (handled above).
               if (!STICKY && !w_cand) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_enter = (w_state_nxt == S_BLOCKED) && (r_state != S_BLOCKED);

   // State and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Entry pulse and capture registers, loaded only when entering BLOCKED.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_event    <= 1'b0;
         r_axis_id  <= '0;
         r_sub_mask <= '0;
      end else begin
         r_event <= w_enter;
         if (w_enter) begin
            r_axis_id  <= w_low_id;
            r_sub_mask <= w_sub_hit;
         end
      end
   end

   assign block          = (r_state == S_BLOCKED);
   assign block_event    = r_event;
   assign block_axis_id  = r_axis_id;
   assign block_sub_mask = r_sub_mask;

endmodule
